// File: rtl/edge_event_arbiter.sv
// Multi-channel edge detector with one pending slot per channel and a
// round-robin output register that presents one event at a time over valid/ready.
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_CH-1:0]   in,
  input  logic [2*N_CH-1:0] mode,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_ch,
  output logic [1:0]        evt_type,
  output logic [N_CH-1:0]   drop,
  input  logic              drop_clr
);

  logic [N_CH-1:0]      in_d;
  logic [N_CH-1:0]      rise;
  logic [N_CH-1:0]      fall;
  logic [N_CH-1:0]      hit;
  logic [N_CH-1:0]      pending;
  logic [N_CH-1:0]      taken;
  logic [N_CH-1:0]      overflow;
  logic [N_CH-1:0][1:0] ptype;
  logic [ID_W-1:0]      rr_last;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      hi_idx;
  logic [ID_W-1:0]      lo_idx;
  logic                 hi_found;
  logic                 out_free;
  logic                 load;

  assign rise     = in & ~in_d;
  assign fall     = ~in & in_d;
  assign out_free = ~evt_valid | evt_ready;
  assign load     = out_free & (|pending);

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit[i] = (rise[i] & mode[2*i]) | (fall[i] & mode[2*i+1]);
    end
  end

  // Round robin: lowest pending index above rr_last, else wrap to lowest pending overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (pending[j]) begin
        lo_idx = ID_W'(j);
        if (j > int'(rr_last)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(j);
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    taken    = '0;
    overflow = '0;
    for (int i = 0; i < N_CH; i++) begin
      taken[i]    = load && (int'(winner) == i);
      overflow[i] = hit[i] & pending[i] & ~taken[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_d <= '0;
    end else begin
      in_d <= in;
    end
  end

  // A slot being handed to the output this cycle can accept a new edge without loss.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
      ptype   <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (hit[i] && (!pending[i] || taken[i])) begin
          pending[i] <= 1'b1;
          ptype[i]   <= {fall[i], rise[i]};
        end else if (taken[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop <= '0;
    end else begin
      drop <= (drop & ~{N_CH{drop_clr}}) | overflow;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_type  <= '0;
      rr_last   <= ID_W'(N_CH - 1);
    end else if (out_free) begin
      if (load) begin
        evt_valid <= 1'b1;
        evt_ch    <= winner;
        evt_type  <= ptype[winner];
        rr_last   <= winner;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized and directed bench for edge_event_arbiter, checked each cycle
// against an event-level reference model.
module tb_edge_event_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rstn;
  logic [N-1:0] ch_in;
  logic [2*N-1:0] mode;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_ch;
  logic [1:0]   evt_type;
  logic [N-1:0] drop;
  logic         drop_clr;

  int cmp_count  = 0;
  int fail_count = 0;
  int acc_count  = 0;

  // Reference model state: what the block should hold after each edge.
  logic [N-1:0] m_in_d;
  logic [N-1:0] m_pend;
  logic [1:0]   m_ptype [N];
  logic         m_valid;
  int           m_ch;
  logic [1:0]   m_tout;
  int           m_rr;
  logic [N-1:0] m_drop;

  edge_event_arbiter #(.N_CH(N), .ID_W(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in        (ch_in),
    .mode      (mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_type  (evt_type),
    .drop      (drop),
    .drop_clr  (drop_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_in_d  = '0;
    m_pend  = '0;
    for (int i = 0; i < N; i++) m_ptype[i] = 2'b00;
    m_valid = 1'b0;
    m_ch    = 0;
    m_tout  = 2'b00;
    m_rr    = N - 1;
    m_drop  = '0;
  endtask

  // One clock of the model: serve the output from the old pending set, then record new edges.
  task automatic modelStep();
    logic         free;
    int           w;
    int           c;
    logic         r;
    logic         f;
    logic [N-1:0] lost;
    free = !m_valid || evt_ready;
    if (m_valid && evt_ready) acc_count++;
    w = -1;
    if (free) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_rr + k) % N;
        if (w < 0 && m_pend[c]) w = c;
      end
      if (w >= 0) begin
        m_valid   = 1'b1;
        m_ch      = w;
        m_tout    = m_ptype[w];
        m_rr      = w;
        m_pend[w] = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    lost = '0;
    for (int i = 0; i < N; i++) begin
      r = ch_in[i] && !m_in_d[i];
      f = !ch_in[i] && m_in_d[i];
      if ((r && mode[2*i]) || (f && mode[2*i+1])) begin
        if (!m_pend[i]) begin
          m_pend[i]  = 1'b1;
          m_ptype[i] = {f, r};
        end else begin
          lost[i] = 1'b1;
        end
      end
    end
    m_drop = (drop_clr ? '0 : m_drop) | lost;
    m_in_d = ch_in;
  endtask

  task automatic compareModel();
    checkOutput("evt_valid", 32'(evt_valid), 32'(m_valid));
    checkOutput("evt_ch", 32'(evt_ch), 32'(m_ch));
    checkOutput("evt_type", 32'(evt_type), 32'(m_tout));
    checkOutput("drop", 32'(drop), 32'(m_drop));
  endtask

  task automatic applyStimulus(input logic [N-1:0] i, input logic [2*N-1:0] m,
                               input logic rdy, input logic clr);
    @(negedge clk);
    ch_in     = i;
    mode      = m;
    evt_ready = rdy;
    drop_clr  = clr;
    @(posedge clk);
    modelStep();
    #1;
    compareModel();
  endtask

  task automatic doReset();
    @(negedge clk);
    ch_in     = '0;
    evt_ready = 1'b0;
    drop_clr  = 1'b0;
    rstn      = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_valid", 32'(evt_valid), 32'd0);
    checkOutput("rst_ch", 32'(evt_ch), 32'd0);
    checkOutput("rst_type", 32'(evt_type), 32'd0);
    checkOutput("rst_drop", 32'(drop), 32'd0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_hold_valid", 32'(evt_valid), 32'd0);
    end
    rstn = 1'b1;
  endtask

  initial begin
    logic [N-1:0]   ri;
    logic [2*N-1:0] rm;
    rstn      = 1'b0;
    ch_in     = '0;
    mode      = '0;
    evt_ready = 1'b0;
    drop_clr  = 1'b0;
    doReset();

    $display("[TB] single rising edge on ch0");
    repeat (3) applyStimulus(4'b0000, 8'b0000_0001, 1'b1, 1'b0);
    applyStimulus(4'b0001, 8'b0000_0001, 1'b1, 1'b0);
    checkOutput("t1_not_yet", 32'(evt_valid), 32'd0);
    applyStimulus(4'b0001, 8'b0000_0001, 1'b1, 1'b0);
    checkOutput("t1_valid", 32'(evt_valid), 32'd1);
    checkOutput("t1_ch", 32'(evt_ch), 32'd0);
    checkOutput("t1_type", 32'(evt_type), 32'd1);
    applyStimulus(4'b0001, 8'b0000_0001, 1'b1, 1'b0);
    checkOutput("t1_one_cycle", 32'(evt_valid), 32'd0);
    applyStimulus(4'b0000, 8'b0000_0001, 1'b1, 1'b0);
    applyStimulus(4'b0000, 8'b0000_0001, 1'b1, 1'b0);
    checkOutput("t1_no_fall", 32'(evt_valid), 32'd0);

    $display("[TB] four simultaneous rising edges");
    doReset();
    acc_count = 0;
    applyStimulus(4'b1111, 8'hFF, 1'b1, 1'b0);
    repeat (6) applyStimulus(4'b1111, 8'hFF, 1'b1, 1'b0);
    checkOutput("t2_accepted", 32'(acc_count), 32'd4);

    $display("[TB] overflow on ch2 with ready low");
    doReset();
    acc_count = 0;
    for (int k = 0; k < 6; k++)
      applyStimulus((k % 2) ? 4'b0100 : 4'b0000, 8'b0001_0000, 1'b0, 1'b0);
    checkOutput("t3_drop2", 32'(drop[2]), 32'd1);
    repeat (5) applyStimulus(4'b0100, 8'b0001_0000, 1'b1, 1'b0);
    checkOutput("t3_accepted", 32'(acc_count), 32'd2);

    $display("[TB] drop_clr colliding with new overflow");
    doReset();
    applyStimulus(4'b0010, 8'b0000_0100, 1'b0, 1'b0);
    applyStimulus(4'b0000, 8'b0000_0100, 1'b0, 1'b0);
    applyStimulus(4'b0010, 8'b0000_0100, 1'b0, 1'b0);
    applyStimulus(4'b0000, 8'b0000_0100, 1'b0, 1'b0);
    applyStimulus(4'b0010, 8'b0000_0100, 1'b0, 1'b1);
    checkOutput("t4_set_wins", 32'(drop[1]), 32'd1);
    applyStimulus(4'b0010, 8'b0000_0100, 1'b0, 1'b1);
    checkOutput("t4_cleared", 32'(drop), 32'd0);

    $display("[TB] fairness between ch0 and ch3");
    doReset();
    ri = '0;
    for (int k = 0; k < 20; k++) begin
      ri = (k % 2) ? (ri ^ 4'b1000) : (ri ^ 4'b0001);
      applyStimulus(ri, 8'b1100_0011, 1'b1, 1'b0);
    end
    checkOutput("t5_no_drop", 32'(drop), 32'd0);

    $display("[TB] reset with busy output and pending entries");
    applyStimulus(4'b0000, 8'hFF, 1'b0, 1'b0);
    applyStimulus(4'b0001, 8'hFF, 1'b0, 1'b0);
    applyStimulus(4'b0111, 8'hFF, 1'b0, 1'b0);
    checkOutput("t6_busy", 32'(evt_valid), 32'd1);
    doReset();
    repeat (4) applyStimulus(4'b0000, 8'hFF, 1'b1, 1'b0);
    checkOutput("t6_no_stale", 32'(evt_valid), 32'd0);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 400; k++) begin
      ri = N'($urandom());
      rm = (2*N)'($urandom());
      applyStimulus(ri, rm, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      if (k == 200) doReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
